// File: rtl/id_issue_ctrl_pkg.sv
// Shared CPU constants for the ID issue controller
// and for the mult/div unit.
package id_issue_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int GPR_NUM = 32;
  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;

endpackage

// File: rtl/id_scoreboard.sv
// Busy bits for GPRs awaiting a load write-back.
// Read ports report busy net of a same-cycle write-back.
module id_scoreboard
  import id_issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] rs_idx,
  input  logic [4:0] rt_idx,
  input  logic [4:0] wd_idx,
  output logic       rs_busy,
  output logic       rt_busy,
  output logic       wd_busy
);

  logic [GPR_NUM-1:0] busy_q;
  logic [GPR_NUM-1:0] busy_d;
  logic [GPR_NUM-1:0] eff_busy;

  // A write-back frees its register in the cycle it arrives.
  always_comb begin
    eff_busy = busy_q;
    if (clr_en) eff_busy[clr_idx] = 1'b0;
  end

  assign rs_busy = eff_busy[rs_idx];
  assign rt_busy = eff_busy[rt_idx];
  assign wd_busy = eff_busy[wd_idx];

  // Clear first, then set, so a new load wins a collision.
  always_comb begin
    busy_d = eff_busy;
    if (set_en) busy_d[set_idx] = 1'b1;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) busy_q <= '0;
    else         busy_q <= busy_d;
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue control: RAW/WAW load hazards,
// HI/LO occupancy and stall-cycle counting.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_wdest,
  input  logic        id_is_load,
  input  logic        id_is_muldiv,
  input  logic        id_is_div,
  input  logic        id_use_hilo,
  input  logic        ex_allowin,
  input  logic        ld_wb_valid,
  input  logic [4:0]  ld_wb_dest,
  input  logic        flush,
  output logic        id_fire,
  output logic        id_stall,
  output logic        muldiv_start,
  output logic        hilo_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MUL_V = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_V = CNT_W'(DIV_LAT);

  logic             rs_busy, rt_busy, wd_busy;
  logic             hazard;
  logic             sb_set;
  logic [CNT_W-1:0] hilo_q, hilo_d;
  logic [31:0]      stall_q, stall_d;

  assign sb_set = id_fire & id_is_load
                & (id_wdest != REG_ZERO);

  id_scoreboard u_sb (
    .clk     (clk),
    .resetn  (resetn),
    .set_en  (sb_set),
    .set_idx (id_wdest),
    .clr_en  (ld_wb_valid),
    .clr_idx (ld_wb_dest),
    .rs_idx  (id_rs),
    .rt_idx  (id_rt),
    .wd_idx  (id_wdest),
    .rs_busy (rs_busy),
    .rt_busy (rt_busy),
    .wd_busy (wd_busy)
  );

  // Issue decision from decoded fields and current state.
  always_comb begin
    hazard = id_valid & (
        (id_use_rs & (id_rs != REG_ZERO) & rs_busy)
      | (id_use_rt & (id_rt != REG_ZERO) & rt_busy)
      | (id_is_load & (id_wdest != REG_ZERO) & wd_busy)
      | ((id_use_hilo | id_is_muldiv) & hilo_busy));
    id_fire      = id_valid & ~hazard & ex_allowin & ~flush;
    id_stall     = id_valid & ~id_fire & ~flush;
    muldiv_start = id_fire & id_is_muldiv;
  end

  // HI/LO countdown, reloaded only when idle.
  always_comb begin
    hilo_d = hilo_q;
    if (muldiv_start)
      hilo_d = id_is_div ? DIV_V : MUL_V;
    else if (hilo_q != '0)
      hilo_d = hilo_q - 1'b1;
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_d = stall_q;
    if (id_stall && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hilo_q  <= '0;
      stall_q <= '0;
    end else begin
      hilo_q  <= hilo_d;
      stall_q <= stall_d;
    end
  end

  assign hilo_busy = (hilo_q != '0);
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl.
// Expected values are worked out by hand per step.
module tb_id_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_wdest;
  logic        id_use_rs, id_use_rt;
  logic        id_is_load, id_is_muldiv, id_is_div;
  logic        id_use_hilo, ex_allowin;
  logic        ld_wb_valid;
  logic [4:0]  ld_wb_dest;
  logic        flush;
  logic        id_fire, id_stall, muldiv_start, hilo_busy;
  logic [31:0] stall_cnt;

  int ntest = 0;
  int nfail = 0;

  id_issue_ctrl #(
    .MUL_LAT (4),
    .DIV_LAT (32),
    .CNT_W   (6)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_wdest     (id_wdest),
    .id_is_load   (id_is_load),
    .id_is_muldiv (id_is_muldiv),
    .id_is_div    (id_is_div),
    .id_use_hilo  (id_use_hilo),
    .ex_allowin   (ex_allowin),
    .ld_wb_valid  (ld_wb_valid),
    .ld_wb_dest   (ld_wb_dest),
    .flush        (flush),
    .id_fire      (id_fire),
    .id_stall     (id_stall),
    .muldiv_start (muldiv_start),
    .hilo_busy    (hilo_busy),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0;
    id_use_rs = 0; id_use_rt = 0; id_wdest = 0;
    id_is_load = 0; id_is_muldiv = 0; id_is_div = 0;
    id_use_hilo = 0; ex_allowin = 1;
    ld_wb_valid = 0; ld_wb_dest = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lw(input logic [4:0] d);
    idle();
    id_valid = 1; id_is_load = 1; id_wdest = d;
  endtask

  task automatic rd(input logic [4:0] rs,
                    input logic [4:0] rt);
    idle();
    id_valid = 1; id_use_rs = 1; id_use_rt = 1;
    id_rs = rs; id_rt = rt; id_wdest = 5'd20;
  endtask

  task automatic md(input logic is_div);
    idle();
    id_valid = 1; id_is_muldiv = 1; id_is_div = is_div;
  endtask

  task automatic mflo();
    idle();
    id_valid = 1; id_use_hilo = 1; id_wdest = 5'd21;
  endtask

  initial begin
    idle();
    resetn = 0;
    #12;
    chk("rst_fire", {31'd0, id_fire}, 32'd0);
    chk("rst_stall", {31'd0, id_stall}, 32'd0);
    chk("rst_mds", {31'd0, muldiv_start}, 32'd0);
    chk("rst_hilo", {31'd0, hilo_busy}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    resetn = 1;
    tick();

    // load-use on $5
    lw(5'd5); #1;
    chk("lw5_fire", {31'd0, id_fire}, 32'd1);
    tick();
    rd(5'd5, 5'd3); #1;
    chk("lu_stall0", {31'd0, id_stall}, 32'd1);
    chk("lu_fire0", {31'd0, id_fire}, 32'd0);
    tick(); #1;
    chk("lu_stall1", {31'd0, id_stall}, 32'd1);
    tick();
    ld_wb_valid = 1; ld_wb_dest = 5'd5; #1;
    chk("lu_wb_fire", {31'd0, id_fire}, 32'd1);
    chk("lu_wb_stall", {31'd0, id_stall}, 32'd0);
    chk("lu_cnt", stall_cnt, 32'd2);
    tick();

    // $0 is never busy
    lw(5'd0); #1;
    chk("lw0_fire", {31'd0, id_fire}, 32'd1);
    tick();
    rd(5'd0, 5'd0); #1;
    chk("r0_fire", {31'd0, id_fire}, 32'd1);
    tick();
    // rt not used while $5 busy
    lw(5'd5); tick();
    rd(5'd1, 5'd5); id_use_rt = 0; #1;
    chk("nouse_fire", {31'd0, id_fire}, 32'd1);
    rd(5'd5, 5'd1); #1;
    chk("r5_stall", {31'd0, id_stall}, 32'd1);
    tick();

    // set/clear collision on $7 (wb of idle $7)
    lw(5'd7); ld_wb_valid = 1; ld_wb_dest = 5'd7; #1;
    chk("col_fire", {31'd0, id_fire}, 32'd1);
    tick();
    rd(5'd7, 5'd0); #1;
    chk("col_stall", {31'd0, id_stall}, 32'd1);
    tick();
    // WAW: load to busy $5
    lw(5'd5); #1;
    chk("waw_stall", {31'd0, id_stall}, 32'd1);
    tick();
    rd(5'd7, 5'd0);
    ld_wb_valid = 1; ld_wb_dest = 5'd7; #1;
    chk("r7_wb_fire", {31'd0, id_fire}, 32'd1);
    tick();
    idle(); ld_wb_valid = 1; ld_wb_dest = 5'd5;
    tick();

    // ex_allowin and flush
    lw(5'd8); tick();
    rd(5'd1, 5'd2); ex_allowin = 0; #1;
    chk("exa_stall", {31'd0, id_stall}, 32'd1);
    chk("exa_fire", {31'd0, id_fire}, 32'd0);
    tick();
    lw(5'd9); flush = 1; #1;
    chk("fl_stall", {31'd0, id_stall}, 32'd0);
    chk("fl_fire", {31'd0, id_fire}, 32'd0);
    tick();
    rd(5'd9, 5'd0); #1;
    chk("fl_r9_fire", {31'd0, id_fire}, 32'd1);
    rd(5'd8, 5'd0); #1;
    chk("fl_r8_stall", {31'd0, id_stall}, 32'd1);
    tick();
    idle(); ld_wb_valid = 1; ld_wb_dest = 5'd8;
    tick();
    // stalls so far: 2+1+1+1+1+1 = 7
    idle(); #1;
    chk("cnt7", stall_cnt, 32'd7);

    // divide then mflo
    md(1'b1); #1;
    chk("div_mds", {31'd0, muldiv_start}, 32'd1);
    chk("div_fire", {31'd0, id_fire}, 32'd1);
    tick();
    md(1'b0); #1;
    chk("hl_busy1", {31'd0, hilo_busy}, 32'd1);
    chk("mul2_stall", {31'd0, id_stall}, 32'd1);
    chk("mul2_mds", {31'd0, muldiv_start}, 32'd0);
    tick();
    mflo();
    for (int i = 2; i <= 32; i++) begin
      #1;
      if (i == 32) begin
        chk("hl_busy32", {31'd0, hilo_busy}, 32'd1);
        chk("mflo_stall32", {31'd0, id_stall}, 32'd1);
      end
      tick();
    end
    #1;
    chk("hl_free33", {31'd0, hilo_busy}, 32'd0);
    chk("mflo_fire33", {31'd0, id_fire}, 32'd1);
    chk("cnt39", stall_cnt, 32'd39);
    tick();

    // mult latency 4
    md(1'b0); tick();
    mflo();
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("mul_busy", {31'd0, hilo_busy}, 32'd1);
      tick();
    end
    #1;
    chk("mul_mflo_fire", {31'd0, id_fire}, 32'd1);
    tick();
    // stalls: 39 + 4 = 43

    // reset during divide
    md(1'b1); tick();
    lw(5'd10); tick();
    mflo(); tick();
    tick();
    #1;
    chk("pre_rst_cnt", stall_cnt, 32'd45);
    #1;
    resetn = 0; #1;
    chk("rst_hl", {31'd0, hilo_busy}, 32'd0);
    chk("rst_cnt2", stall_cnt, 32'd0);
    #1;
    resetn = 1; #1;
    chk("post_fire", {31'd0, id_fire}, 32'd1);
    tick();
    rd(5'd10, 5'd0); #1;
    chk("post_r10", {31'd0, id_fire}, 32'd1);
    tick();
    idle(); ld_wb_valid = 1; ld_wb_dest = 5'd10;
    tick();
    idle(); #1;
    chk("post_cnt", stall_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             ntest, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
